// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-4 Booth multiplier, one digit per cycle; optional BOOTH_EARLY_TERM_EN early exit
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);
  localparam int E  = WIDTH + 2;
  localparam int AW = E + 2;
  localparam int N  = E / 2;
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         state, state_nxt;
  logic [AW-1:0]  q, a, d, sum;
  logic [E-1:0]   p;
  logic           c, fin, accept;
  logic [CW-1:0]  cnt;
  logic [2:0]     sel;
  logic [AW+E-1:0] ap_step, ap_nxt;
  logic [AW-1:0]  qx, q2;
  logic [E-1:0]   mx;
`ifdef BOOTH_EARLY_TERM_EN
  logic [CW:0]    sh;
  logic [E-1:0]   m;
  logic           term;
  logic signed [AW+E-1:0] aps;
`endif
  // Operand widening, Booth digit selection and one shift-add step
  always_comb begin
    qx      = is_signed ? {{4{multiplicand[WIDTH-1]}}, multiplicand} : {4'b0, multiplicand};
    mx      = is_signed ? {{2{multiplier[WIDTH-1]}}, multiplier} : {2'b0, multiplier};
    q2      = {q[AW-2:0], 1'b0};
    sel     = {p[1:0], c};
    d       = (sel == 3'b001 || sel == 3'b010) ? q :
              (sel == 3'b011) ? q2 :
              (sel == 3'b100) ? -q2 :
              (sel == 3'b101 || sel == 3'b110) ? -q : '0;
    sum     = a + d;
    ap_step = {{2{sum[AW-1]}}, sum, p[E-1:2]};
`ifdef BOOTH_EARLY_TERM_EN
    sh      = {cnt, 1'b0} + (CW+1)'(2);
    m       = ~({E{1'b1}} << sh);
    term    = (((p & m) == '0) && !c) || (((p & m) == m) && c);
    aps     = {a, p};
    ap_nxt  = term ? aps >>> sh : ap_step;
    fin     = term || cnt == '0;
`else
    ap_nxt  = ap_step;
    fin     = cnt == '0;
`endif
  end
  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = start ? RUN : IDLE;
      RUN:     state_nxt = fin ? DONE : RUN;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
    busy   = state == RUN;
    done   = state == DONE;
    accept = start && (state == IDLE || state == DONE);
  end
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // Datapath: latch operands on accept, step in RUN, capture product on the last step
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q    <= '0;
      a    <= '0;
      p    <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      prod <= '0;
    end else if (accept) begin
      q   <= qx;
      a   <= '0;
      p   <= mx;
      c   <= 1'b0;
      cnt <= CW'(N - 1);
    end else if (state == RUN) begin
      {a, p} <= ap_nxt;
      c      <= p[1];
      cnt    <= cnt - 1'b1;
      if (fin) prod <= ap_nxt[2*WIDTH-1:0];
    end
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: vector table, handshake corner cases and random ops against an arithmetic model
module tb_booth_mul_seq;
  localparam int W = 32;
  localparam int N = W / 2 + 1;
  logic           clk = 1'b0, rst_n = 1'b0, start = 1'b0, is_signed = 1'b0;
  logic [W-1:0]   multiplicand = '0, multiplier = '0;
  logic           busy, done;
  logic [2*W-1:0] prod;
  int total = 0, bad = 0;

  booth_mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .prod(prod)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           s;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] exp;
  } vec_t;

  function automatic logic [2*W-1:0] ref_mul(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] xe, ye;
    xe = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
    ye = s ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
    return xe * ye;
  endfunction

  task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_lat(input string nm, input int lat);
`ifdef BOOTH_EARLY_TERM_EN
    chk(nm, 64'(lat >= 1 && lat <= N), 64'd1);
`else
    chk(nm, 64'(lat), 64'(N));
`endif
  endtask

  // drives start for one edge, then scrambles the inputs so late changes must be ignored
  task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; is_signed = s; multiplicand = x; multiplier = y;
    @(negedge clk);
    start = 1'b0; is_signed = 1'($urandom); multiplicand = $urandom; multiplier = $urandom;
  endtask

  task automatic wait_done(output int lat, output bit ok);
    lat = 0; ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin ok = 1; break; end
      if (busy) lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string nm, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2*W-1:0] exp);
    int lat; bit ok;
    issue(s, x, y);
    wait_done(lat, ok);
    chk({nm, "_done"}, 64'(ok), 64'd1);
    chk({nm, "_prod"}, prod, exp);
    chk_lat({nm, "_lat"}, lat);
  endtask

  initial begin
    vec_t vt[$];
    int lat; bit ok;
    logic s; logic [W-1:0] x, y;
    vt.push_back('{1'b1, -32'sd3, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB});
    vt.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001});
    vt.push_back('{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001});
    vt.push_back('{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000});
    vt.push_back('{1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000});
    vt.push_back('{1'b0, 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000});
    vt.push_back('{1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000});
    vt.push_back('{1'b1, 32'd5, 32'd1, 64'd5});
    vt.push_back('{1'b0, 32'd0, 32'hDEAD_BEEF, 64'd0});
    vt.push_back('{1'b1, 32'd1000, -32'sd1000, -64'sd1000000});

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_prod", prod, 64'd0);
    rst_n = 1'b1;

    foreach (vt[i]) run_op($sformatf("vec%0d", i), vt[i].s, vt[i].x, vt[i].y, vt[i].exp);

`ifdef BOOTH_EARLY_TERM_EN
    issue(1'b1, 32'd5, 32'd1);
    wait_done(lat, ok);
    chk("early_5x1", prod, 64'd5);
    chk("early_5x1_lat", 64'(lat <= 2), 64'd1);
    issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, ok);
    chk("early_m1", prod, 64'd1);
    chk("early_m1_lat", 64'(lat < N), 64'd1);
`endif

    // start with new operands mid-RUN is ignored; start held in DONE is accepted with no gap
    issue(1'b1, 32'h7654_3210, 32'h5A5A_5A5A);
    repeat (3) @(negedge clk);
    chk("midrun_busy", 64'(busy), 64'd1);
    start = 1'b1; is_signed = 1'b0; multiplicand = 32'h1111_1111; multiplier = 32'h2222_2222;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, ok);
    chk("midrun_done", 64'(ok), 64'd1);
    chk("midrun_prod", prod, ref_mul(1'b1, 32'h7654_3210, 32'h5A5A_5A5A));
    start = 1'b1; is_signed = 1'b0; multiplicand = 32'hCAFE_F00D; multiplier = 32'h1357_9BDF;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done(lat, ok);
    chk("b2b_done", 64'(ok), 64'd1);
    chk("b2b_prod", prod, ref_mul(1'b0, 32'hCAFE_F00D, 32'h1357_9BDF));
    chk_lat("b2b_lat", lat);

    // reset in RUN cycle 5 aborts at once
    issue(1'b1, 32'h7FFF_FFF1, 32'h5555_5555);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_prod", prod, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_nodone", 64'(done), 64'd0);
    run_op("after_abort", 1'b1, 32'd6, 32'd6, 64'd36);

    for (int i = 0; i < 300; i++) begin
      s = 1'($urandom);
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 5))
        0: x = 32'h8000_0000;
        1: y = 32'hFFFF_FFFF;
        2: y = 32'($urandom_range(0, 7));
        default: ;
      endcase
      issue(s, x, y);
      wait_done(lat, ok);
      chk($sformatf("rnd%0d_done", i), 64'(ok), 64'd1);
      chk($sformatf("rnd%0d_prod", i), prod, ref_mul(s, x, y));
      chk_lat($sformatf("rnd%0d_lat", i), lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
